// File: rtl/timer_programable_if.sv
// Control/status bundle of the programmable interval timer.
// The master drives the controls; the slave is the timer itself.
interface timer_programable_if #(
  parameter int unsigned WIDTH  = 22,
  parameter int unsigned TCNT_W = 8
);
  logic              EN;
  logic              start;
  logic              stop;
  logic              mode;
  logic [WIDTH-1:0]  period;
  logic              done_clr;
  logic [WIDTH-1:0]  cuenta;
  logic              tick;
  logic              running;
  logic              done;
  logic [TCNT_W-1:0] n_ticks;

  modport master (
    output EN, start, stop, mode, period, done_clr,
    input  cuenta, tick, running, done, n_ticks
  );

  modport slave (
    input  EN, start, stop, mode, period, done_clr,
    output cuenta, tick, running, done, n_ticks
  );
endinterface

// File: rtl/timer_programable.sv
// Programmable periodic/one-shot interval timer with start/stop control,
// count enable, registered one-cycle tick, sticky done flag and tick counter.
module timer_programable #(
  parameter int unsigned WIDTH          = 22,
  parameter int unsigned DEFAULT_PERIOD = 2000000,
  parameter int unsigned TCNT_W         = 8
) (
  input logic                clk,
  input logic                rst,
  timer_programable_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    cuenta_q, cuenta_d;
  logic [WIDTH-1:0]    period_q, period_d;
  logic                mode_q, mode_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;
  logic [TCNT_W-1:0]   n_ticks_q, n_ticks_d;

  logic [WIDTH-1:0]    eff_period;
  logic                wrap;

  // A zero period would never wrap; treat it as one cycle.
  assign eff_period = (bus.period == '0) ? WIDTH'(1) : bus.period;
  assign wrap       = (cuenta_q == period_q - WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    cuenta_d  = cuenta_q;
    period_d  = period_q;
    mode_d    = mode_q;
    tick_d    = 1'b0;
    n_ticks_d = n_ticks_q;
    done_d    = bus.done_clr ? 1'b0 : done_q;

    if (bus.stop) begin
      state_d  = StIdle;
      cuenta_d = '0;
    end else if (bus.start) begin
      state_d   = StRun;
      cuenta_d  = '0;
      n_ticks_d = '0;
      done_d    = 1'b0;
      period_d  = eff_period;
      mode_d    = bus.mode;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.EN) begin
            if (wrap) begin
              cuenta_d = '0;
              tick_d   = 1'b1;
              if (n_ticks_q != '1) begin
                n_ticks_d = n_ticks_q + TCNT_W'(1);
              end
              if (mode_q) begin
                state_d = StDone;
                done_d  = 1'b1;  // set beats a same-cycle done_clr
              end else begin
                period_d = eff_period;
              end
            end else begin
              cuenta_d = cuenta_q + WIDTH'(1);
            end
          end
        end
        StIdle, StDone: begin
          cuenta_d = '0;
        end
        default: begin
          state_d  = StIdle;
          cuenta_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cuenta_q  <= '0;
      period_q  <= WIDTH'(DEFAULT_PERIOD);
      mode_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      n_ticks_q <= '0;
    end else begin
      state_q   <= state_d;
      cuenta_q  <= cuenta_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      n_ticks_q <= n_ticks_d;
    end
  end

  assign bus.cuenta  = cuenta_q;
  assign bus.tick    = tick_q;
  assign bus.running = (state_q == StRun);
  assign bus.done    = done_q;
  assign bus.n_ticks = n_ticks_q;

endmodule

// File: tb/tb_timer_programable.sv
// Self-checking bench for timer_programable: per-cycle vector table run through
// an expectation queue, plus hand-written latency and reset checks.
module tb_timer_programable;

  localparam int unsigned WIDTH  = 22;
  localparam int unsigned TCNT_W = 3;

  typedef struct {
    string             name;
    logic              rst;
    logic              en;
    logic              start;
    logic              stop;
    logic              mode;
    logic [WIDTH-1:0]  period;
    logic              clr;
    logic [WIDTH-1:0]  cuenta;
    logic              tick;
    logic              running;
    logic              done;
    logic [TCNT_W-1:0] n_ticks;
  } vec_t;

  logic clk;
  logic rst;
  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec;
  int   n_err;

  timer_programable_if #(.WIDTH(WIDTH), .TCNT_W(TCNT_W)) bus ();

  timer_programable #(
    .WIDTH          (WIDTH),
    .DEFAULT_PERIOD (2000000),
    .TCNT_W         (TCNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string name, input logic r, e, st, sp, md, input int per,
                     input logic clr, input int cu, input logic tk, run, dn, input int nt);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.start = st; v.stop = sp; v.mode = md;
    v.period = WIDTH'(per); v.clr = clr; v.cuenta = WIDTH'(cu); v.tick = tk;
    v.running = run; v.done = dn; v.n_ticks = TCNT_W'(nt);
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst          = v.rst;
    bus.EN       = v.en;
    bus.start    = v.start;
    bus.stop     = v.stop;
    bus.mode     = v.mode;
    bus.period   = v.period;
    bus.done_clr = v.clr;
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (bus.cuenta !== e.cuenta || bus.tick !== e.tick || bus.running !== e.running ||
        bus.done !== e.done || bus.n_ticks !== e.n_ticks) begin
      n_err++;
      $display("FAIL %s: got cuenta=%0d tick=%b running=%b done=%b n_ticks=%0d, want cuenta=%0d tick=%b running=%b done=%b n_ticks=%0d",
               e.name, bus.cuenta, bus.tick, bus.running, bus.done, bus.n_ticks,
               e.cuenta, e.tick, e.running, e.done, e.n_ticks);
    end
  endtask

  initial begin
    vec_t idle;
    int   cyc;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1; bus.EN = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.mode = 1'b0; bus.period = '0; bus.done_clr = 1'b0;

    // name, rst en start stop mode period clr | cuenta tick running done n_ticks
    add("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("reset", 1, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);

    // Periodic, P=5: ticks after edges 5, 10, 15
    add("per_start", 0, 1, 1, 0, 0, 5, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      for (int c = 1; c <= 4; c++) add("per_count", 0, 1, 0, 0, 0, 5, 0, c, 0, 1, 0, k - 1);
      add("per_tick", 0, 1, 0, 0, 0, 5, 0, 0, 1, 1, 0, k);
    end
    add("per_after", 0, 1, 0, 0, 0, 5, 0, 1, 0, 1, 0, 3);

    // One-shot, P=3
    add("os_start", 0, 1, 1, 0, 1, 3, 0, 0, 0, 1, 0, 0);
    add("os_count", 0, 1, 0, 0, 1, 3, 0, 1, 0, 1, 0, 0);
    add("os_count", 0, 1, 0, 0, 1, 3, 0, 2, 0, 1, 0, 0);
    add("os_done", 0, 1, 0, 0, 1, 3, 0, 0, 1, 0, 1, 1);
    add("os_hold", 0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 1, 1);
    add("os_hold", 0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 1, 1);
    add("os_clr", 0, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 1);
    add("os_rearm", 0, 1, 1, 0, 1, 3, 0, 0, 0, 1, 0, 0);
    add("os_count2", 0, 1, 0, 0, 1, 3, 0, 1, 0, 1, 0, 0);
    add("os_count2", 0, 1, 0, 0, 1, 3, 0, 2, 0, 1, 0, 0);
    add("os_set_clr", 0, 1, 0, 0, 1, 3, 1, 0, 1, 0, 1, 1);

    // Gating, P=4, EN low two cycles: tick after edge 6
    add("gate_start", 0, 1, 1, 0, 0, 4, 0, 0, 0, 1, 0, 0);
    add("gate_count", 0, 1, 0, 0, 0, 4, 0, 1, 0, 1, 0, 0);
    add("gate_count", 0, 1, 0, 0, 0, 4, 0, 2, 0, 1, 0, 0);
    add("gate_off", 0, 0, 0, 0, 0, 4, 0, 2, 0, 1, 0, 0);
    add("gate_off", 0, 0, 0, 0, 0, 4, 0, 2, 0, 1, 0, 0);
    add("gate_count", 0, 1, 0, 0, 0, 4, 0, 3, 0, 1, 0, 0);
    add("gate_tick", 0, 1, 0, 0, 0, 4, 0, 0, 1, 1, 0, 1);
    add("gate_stop", 0, 1, 0, 1, 0, 4, 0, 0, 0, 0, 0, 1);

    // Period 0: tick every enabled edge, n_ticks saturates at 7
    add("p0_start", 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 9; i++) add("p0_tick", 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, (i > 7) ? 7 : i);
    add("p0_gated", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7);

    // Reload: P=4 then 2 -> ticks at edges 4, 6, 8
    add("rl_start", 0, 1, 1, 0, 0, 4, 0, 0, 0, 1, 0, 0);
    for (int c = 1; c <= 3; c++) add("rl_count", 0, 1, 0, 0, 0, 2, 0, c, 0, 1, 0, 0);
    add("rl_tick4", 0, 1, 0, 0, 0, 2, 0, 0, 1, 1, 0, 1);
    add("rl_count", 0, 1, 0, 0, 0, 2, 0, 1, 0, 1, 0, 1);
    add("rl_tick6", 0, 1, 0, 0, 0, 2, 0, 0, 1, 1, 0, 2);
    add("rl_count", 0, 1, 0, 0, 0, 2, 0, 1, 0, 1, 0, 2);
    add("rl_tick8", 0, 1, 0, 0, 0, 2, 0, 0, 1, 1, 0, 3);

    // Collisions
    add("start_stop", 0, 1, 1, 1, 0, 2, 0, 0, 0, 0, 0, 3);
    add("sw_start", 0, 1, 1, 0, 0, 2, 0, 0, 0, 1, 0, 0);
    add("sw_count", 0, 1, 0, 0, 0, 2, 0, 1, 0, 1, 0, 0);
    add("start_wrap", 0, 1, 1, 0, 0, 2, 0, 0, 0, 1, 0, 0);
    add("sw_count", 0, 1, 0, 0, 0, 2, 0, 1, 0, 1, 0, 0);
    add("stop_wrap", 0, 1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0);

    // Reset mid-run at cuenta = 5, with start asserted too
    add("rm_start", 0, 1, 1, 0, 0, 8, 0, 0, 0, 1, 0, 0);
    for (int c = 1; c <= 5; c++) add("rm_count", 0, 1, 0, 0, 0, 8, 0, c, 0, 1, 0, 0);
    add("rm_reset", 1, 1, 1, 0, 0, 8, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    n_vec++;
    if (dut.period_q !== WIDTH'(2000000)) begin
      n_err++;
      $display("FAIL rst_period_q: got %0d, want %0d", dut.period_q, 2000000);
    end

    // Start latency: with P=3 the first tick appears 3 edges after start
    idle.name = "lat"; idle.rst = 0; idle.en = 1; idle.start = 1; idle.stop = 0;
    idle.mode = 0; idle.period = WIDTH'(3); idle.clr = 0;
    drive(idle);
    @(posedge clk);
    #1;
    idle.start = 0;
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      drive(idle);
      @(posedge clk);
      #1;
      if (bus.tick === 1'b1) begin
        cyc = i;
        break;
      end
    end
    n_vec++;
    if (cyc != 3) begin
      n_err++;
      $display("FAIL start_latency: got %0d edges (0 = none within budget), want 3", cyc);
    end

    // Ticks spaced P apart with EN high
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      drive(idle);
      @(posedge clk);
      #1;
      if (bus.tick === 1'b1) begin
        cyc = i;
        break;
      end
    end
    n_vec++;
    if (cyc != 3) begin
      n_err++;
      $display("FAIL tick_spacing: got %0d edges (0 = none within budget), want 3", cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
